lfsr_tap_finder: RTL and testbench

LFSR_TAP_FINDER -- requirements
Module: lfsr_tap_finder

---
 rtl/lfsr_tap_finder.sv | 197 +++++++++++++++++++
 tb/tb_lfsr_tap_finder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_tap_finder.sv
// lfsr_tap_finder: searches a fixed table of NTAP tap patterns for one that
// takes an LFSR from `seed` to `target` in exactly `steps` shifts.
// Candidates are tried in index order and each one restarts from the seed.
// Optional feature: define LFSR_TF_MATCHMASK_EN to add the match_mask output.
// With it defined, every candidate is evaluated and each hit sets its mask bit.
module lfsr_tap_finder #(
  parameter int unsigned        W    = 7,
  parameter int unsigned        NTAP = 9,
  parameter int unsigned        SW   = 8,
  parameter logic [NTAP*W-1:0]  TAPS = {7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A,
                                        7'h72, 7'h78, 7'h48, 7'h60}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [W-1:0]            seed,
  input  logic [W-1:0]            target,
  input  logic [SW-1:0]           steps,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [$clog2(NTAP)-1:0] tap_idx,
  output logic [W-1:0]            tap_out
`ifdef LFSR_TF_MATCHMASK_EN
  ,
  output logic [NTAP-1:0]         match_mask
`endif
);

  localparam int unsigned IW = $clog2(NTAP);
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAP - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   seed_q, seed_d;
  logic [W-1:0]   target_q, target_d;
  logic [SW-1:0]  steps_q, steps_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   lfsr_q, lfsr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           found_q, found_d;
  logic [IW-1:0]  tap_idx_q, tap_idx_d;
  logic [W-1:0]   tap_out_q, tap_out_d;
  logic [NTAP-1:0] match_mask_q, match_mask_d;

  logic [W-1:0]   tap_cur;
  logic [W-1:0]   lfsr_next;
  logic           hit;

  // Select the tap pattern of the candidate currently under test.
  always_comb begin
    tap_cur = '0;
    for (int unsigned c = 0; c < NTAP; c++) begin
      if (idx_q == IW'(c)) tap_cur = TAPS[c*W +: W];
    end
  end

  assign lfsr_next = {lfsr_q[W-2:0], ^(lfsr_q & tap_cur)};
  assign hit       = (lfsr_q == target_q);

  // Next-state and next-output computation for the search FSM.
  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    target_d     = target_q;
    steps_d      = steps_q;
    cnt_d        = cnt_q;
    lfsr_d       = lfsr_q;
    idx_d        = idx_q;
    found_d      = found_q;
    tap_idx_d    = tap_idx_q;
    tap_out_d    = tap_out_q;
    match_mask_d = match_mask_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          seed_d       = seed;
          target_d     = target;
          steps_d      = steps;
          idx_d        = '0;
          found_d      = 1'b0;
          tap_idx_d    = '0;
          tap_out_d    = '0;
          match_mask_d = '0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        lfsr_d  = seed_q;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // Counter stops at steps_q, so the full SW-bit range never wraps.
        if (cnt_q == steps_q) begin
          state_d = CHECK;
        end else begin
          lfsr_d = lfsr_next;
          cnt_d  = cnt_q + SW'(1);
        end
      end
      CHECK: begin
`ifdef LFSR_TF_MATCHMASK_EN
        // Keep scanning after a hit; found_q guards the lowest-index report.
        if (hit) begin
          match_mask_d[idx_q] = 1'b1;
          if (!found_q) begin
            found_d   = 1'b1;
            tap_idx_d = idx_q;
            tap_out_d = tap_cur;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = LOAD;
        end
`else
        if (hit) begin
          found_d   = 1'b1;
          tap_idx_d = idx_q;
          tap_out_d = tap_cur;
          state_d   = DONE;
        end else if (idx_q == LAST_IDX) begin
          found_d   = 1'b0;
          tap_idx_d = '0;
          tap_out_d = '0;
          state_d   = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = LOAD;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      seed_q       <= '0;
      target_q     <= '0;
      steps_q      <= '0;
      cnt_q        <= '0;
      lfsr_q       <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      tap_idx_q    <= '0;
      tap_out_q    <= '0;
      match_mask_q <= '0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      target_q     <= target_d;
      steps_q      <= steps_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
      tap_idx_q    <= tap_idx_d;
      tap_out_q    <= tap_out_d;
      match_mask_q <= match_mask_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign found   = found_q;
  assign tap_idx = tap_idx_q;
  assign tap_out = tap_out_q;
`ifdef LFSR_TF_MATCHMASK_EN
  assign match_mask = match_mask_q;
`else
  logic unused_mask;
  assign unused_mask = ^match_mask_q;
`endif

endmodule

// File: tb/tb_lfsr_tap_finder.sv
// Scoreboard bench for lfsr_tap_finder (W=7, NTAP=9, default taps).
// Stimulus pushes reference results; a monitor pops them on each done pulse.
module tb_lfsr_tap_finder;

  localparam int W    = 7;
  localparam int NTAP = 9;
  localparam int SW   = 8;
  localparam int IW   = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  seed;
  logic [W-1:0]  target;
  logic [SW-1:0] steps;
  logic          busy;
  logic          done;
  logic          found;
  logic [IW-1:0] tap_idx;
  logic [W-1:0]  tap_out;
`ifdef LFSR_TF_MATCHMASK_EN
  logic [NTAP-1:0] match_mask;
`endif

  lfsr_tap_finder #(.W(W), .NTAP(NTAP), .SW(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .seed    (seed),
    .target  (target),
    .steps   (steps),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .tap_idx (tap_idx),
    .tap_out (tap_out)
`ifdef LFSR_TF_MATCHMASK_EN
    ,
    .match_mask (match_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Candidate table in index order.
  int tap_tbl [NTAP] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};

  typedef struct {
    bit found;
    int idx;
    int tap;
    int mask;
    int done_cyc;
  } exp_t;

  exp_t sb_q [$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Shift a W-bit register n times; feedback is the parity of state & tap.
  function automatic int advance(input int s, input int t, input int n);
    int v = s;
    for (int k = 0; k < n; k++) begin
      int fb = $countones(v & t) % 2;
      v = ((v * 2) + fb) % (1 << W);
    end
    return v;
  endfunction

  function automatic exp_t model(input int sd, input int tg, input int st, input int now);
    exp_t e;
    int   k;
    e.found = 0; e.idx = 0; e.tap = 0; e.mask = 0;
    for (int c = 0; c < NTAP; c++) begin
      if (advance(sd, tap_tbl[c], st) == tg) begin
        e.mask = e.mask | (1 << c);
        if (!e.found) begin
          e.found = 1; e.idx = c; e.tap = tap_tbl[c];
        end
      end
    end
`ifdef LFSR_TF_MATCHMASK_EN
    k = NTAP - 1;
`else
    k = e.found ? e.idx : NTAP - 1;
`endif
    e.done_cyc = now + 1 + (k + 1) * (st + 3);
    return e;
  endfunction

  // Called just after a falling edge: present a request for one cycle.
  task automatic issue(input int sd, input int tg, input int st);
    seed   = W'(sd);
    target = W'(tg);
    steps  = SW'(st);
    start  = 1'b1;
    sb_q.push_back(model(sd, tg, st, cyc));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: got no done, required done within 3000 cycles", name);
      sb_q.delete();
    end
  endtask

  task automatic run_txn(input string name, input int sd, input int tg, input int st);
    @(negedge clk);
    issue(sd, tg, st);
    wait_done(name);
  endtask

  // Monitor: compare each done pulse against the oldest expected result.
  initial begin
    bit prev_done = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_done) chk("done_pulse_width", int'(done), 0);
      if (done) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, required no pending request");
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("found", int'(found), int'(e.found));
          chk("tap_idx", int'(tap_idx), e.idx);
          chk("tap_out", int'(tap_out), e.tap);
          chk("busy_in_done", int'(busy), 1);
`ifdef LFSR_TF_MATCHMASK_EN
          chk("match_mask", int'(match_mask), e.mask);
`endif
        end
      end
      prev_done = done;
    end
  end

  initial begin
    int sd, tg, st;
    rst_n = 1'b1; start = 1'b0; seed = '0; target = '0; steps = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_tap_idx", int'(tap_idx), 0);
    chk("rst_tap_out", int'(tap_out), 0);
    #2 rst_n = 1'b1;

    // Directed cases with hand-derived outcomes.
    run_txn("v_first_tap", 'h01, 'h02, 1);
    run_txn("v_sixth_tap", 'h01, 'h03, 1);
    run_txn("v_zero_steps", 'h55, 'h55, 0);
    run_txn("v_no_match", 'h00, 'h01, 5);

    // A second start while busy is ignored.
    @(negedge clk);
    issue('h01, 'h03, 1);
    repeat (4) @(negedge clk);
    seed = 'h55; target = 'h55; steps = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("v_start_while_busy");

    // Start raised during the done cycle is ignored; held into IDLE it is taken.
    seed = 'h55; target = 'h55; steps = '0; start = 1'b1;
    @(negedge clk);
    issue('h00, 'h01, 2);
    wait_done("v_start_after_done");

    // Full-range step count.
    sd = $urandom_range(1, 127);
    run_txn("v_max_steps", sd, advance(sd, tap_tbl[7], 255), 255);

    // Reset in the middle of RUN abandons the search.
    @(negedge clk);
    issue('h01, 'h7F, 200);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    chk("midrst_found", int'(found), 0);
    chk("midrst_tap_out", int'(tap_out), 0);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    run_txn("v_after_reset", 'h01, 'h03, 1);

    // Randomised requests; half the targets are reachable by some candidate.
    for (int n = 0; n < 25; n++) begin
      sd = int'($urandom_range(0, 127));
      st = int'($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 1)
        tg = advance(sd, tap_tbl[$urandom_range(0, NTAP - 1)], st);
      else
        tg = int'($urandom_range(0, 127));
      run_txn("v_random", sd, tg, st);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
